// File: rtl/mem_pkg.sv
// Shared op encodings, FSM states and lane helpers for the MEM-stage access unit.
// Internal op = {is_store, 3-bit MEM_READ/MEM_WRITE code}.
package mem_pkg;

   localparam logic [3:0] OP_NONE = 4'h0;
   localparam logic [3:0] OP_LB   = 4'h1;
   localparam logic [3:0] OP_LH   = 4'h2;
   localparam logic [3:0] OP_LW   = 4'h3;
   localparam logic [3:0] OP_LBU  = 4'h4;
   localparam logic [3:0] OP_LHU  = 4'h5;
   localparam logic [3:0] OP_SB   = 4'h9;
   localparam logic [3:0] OP_SH   = 4'hA;
   localparam logic [3:0] OP_SW   = 4'hB;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] a);
      logic [7:0] r;
      case (a)
         2'd0:    r = word[7:0];
         2'd1:    r = word[15:8];
         2'd2:    r = word[23:16];
         default: r = word[31:24];
      endcase
      return r;
   endfunction

   function automatic logic [15:0] half_lane(input logic [31:0] word, input logic a1);
      return a1 ? word[31:16] : word[15:0];
   endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: store byte enables/replication, load extraction and
// extension, and the alignment check for the presented op.
module load_store_align
   import mem_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  byteen_o,
   output logic [31:0] store_data_o,
   output logic [31:0] load_data_o,
   output logic        misaligned_o
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   assign rbyte = byte_lane(rdata_i, addr_lo_i);
   assign rhalf = half_lane(rdata_i, addr_lo_i[1]);

   always_comb begin
      byteen_o     = 4'b0000;
      store_data_o = 32'h0;
      load_data_o  = 32'h0;
      misaligned_o = 1'b0;
      case (op_i)
         OP_LB: begin
            byteen_o    = 4'b1111;
            load_data_o = {{24{rbyte[7]}}, rbyte};
         end
         OP_LBU: begin
            byteen_o    = 4'b1111;
            load_data_o = {24'h0, rbyte};
         end
         OP_LH: begin
            byteen_o     = 4'b1111;
            load_data_o  = {{16{rhalf[15]}}, rhalf};
            misaligned_o = addr_lo_i[0];
         end
         OP_LHU: begin
            byteen_o     = 4'b1111;
            load_data_o  = {16'h0, rhalf};
            misaligned_o = addr_lo_i[0];
         end
         OP_LW: begin
            byteen_o     = 4'b1111;
            load_data_o  = rdata_i;
            misaligned_o = |addr_lo_i;
         end
         OP_SB: begin
            byteen_o     = 4'b0001 << addr_lo_i;
            store_data_o = {4{wdata_i[7:0]}};
         end
         OP_SH: begin
            byteen_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            store_data_o = {2{wdata_i[15:0]}};
            misaligned_o = addr_lo_i[0];
         end
         OP_SW: begin
            byteen_o     = 4'b1111;
            store_data_o = wdata_i;
            misaligned_o = |addr_lo_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: request/ack transaction with the data memory,
// load formatting, and BUSY_WAIT to freeze the pipeline until the access completes.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
)(
   input  logic              CLK,
   input  logic              reset,
   input  logic [2:0]        MEM_READ,
   input  logic [2:0]        MEM_WRITE,
   input  logic [ADDR_W-1:0] ADDRESS,
   input  logic [31:0]       WRITE_DATA,
   input  logic [31:0]       DMEM_READDATA,
   input  logic              DMEM_ACK,
   output logic              DMEM_READ,
   output logic              DMEM_WRITE,
   output logic [ADDR_W-1:0] DMEM_ADDR,
   output logic [3:0]        DMEM_BYTEEN,
   output logic [31:0]       DMEM_WRITEDATA,
   output logic [31:0]       LOAD_DATA,
   output logic              BUSY_WAIT,
   output logic              MISALIGNED,
   output logic              BUS_ERROR
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t            state_q;
   logic [3:0]        op_q;
   logic [1:0]        a_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              rd_q, wr_q, berr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wd_q, ld_q;

   logic              rd_valid, wr_valid, in_idle, start, timeout_hit;
   logic [3:0]        cur_op, al_op;
   logic [1:0]        al_a;
   logic [3:0]        al_be;
   logic [31:0]       al_store, al_load;
   logic              al_mis;

   assign rd_valid = (MEM_READ != 3'd0) && (MEM_READ <= 3'd5);
   assign wr_valid = (MEM_WRITE != 3'd0) && !MEM_WRITE[2];

   // A simultaneous load and store resolves to the load; the store is dropped.
   always_comb begin
      cur_op = OP_NONE;
      if (rd_valid)      cur_op = {1'b0, MEM_READ};
      else if (wr_valid) cur_op = {1'b1, MEM_WRITE};
   end

   // In IDLE the aligner sees the incoming op; afterwards it formats against the latched op.
   assign in_idle = (state_q == ST_IDLE);
   assign al_op   = in_idle ? cur_op : op_q;
   assign al_a    = in_idle ? ADDRESS[1:0] : a_q;

   load_store_align u_align (
      .op_i         (al_op),
      .addr_lo_i    (al_a),
      .wdata_i      (WRITE_DATA),
      .rdata_i      (DMEM_READDATA),
      .byteen_o     (al_be),
      .store_data_o (al_store),
      .load_data_o  (al_load),
      .misaligned_o (al_mis)
   );

   assign start       = in_idle && (cur_op != OP_NONE) && !al_mis;
   assign BUSY_WAIT   = !reset && (start || (state_q == ST_ACCESS));
   assign MISALIGNED  = !reset && in_idle && (cur_op != OP_NONE) && al_mis;
   assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

   // Handshake: DMEM_READ/DMEM_WRITE (with addr, lanes, data) are held stable from the
   // first ACCESS cycle until the edge on which DMEM_ACK is sampled high; ACK outside
   // ACCESS has no effect.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NONE;
         a_q     <= 2'd0;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         berr_q  <= 1'b0;
         addr_q  <= '0;
         be_q    <= 4'd0;
         wd_q    <= 32'h0;
         ld_q    <= 32'h0;
      end else begin
         berr_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_ACCESS;
                  op_q    <= cur_op;
                  a_q     <= ADDRESS[1:0];
                  rd_q    <= !cur_op[3];
                  wr_q    <= cur_op[3];
                  addr_q  <= {ADDRESS[ADDR_W-1:2], 2'b00};
                  be_q    <= al_be;
                  wd_q    <= al_store;
                  cnt_q   <= '0;
               end
            end
            ST_ACCESS: begin
               if (DMEM_ACK) begin
                  rd_q    <= 1'b0;
                  wr_q    <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= ST_DONE;
                  if (!op_q[3]) ld_q <= al_load;
               end else if (timeout_hit) begin
                  rd_q    <= 1'b0;
                  wr_q    <= 1'b0;
                  cnt_q   <= '0;
                  ld_q    <= 32'h0;
                  berr_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign DMEM_READ      = rd_q;
   assign DMEM_WRITE     = wr_q;
   assign DMEM_ADDR      = addr_q;
   assign DMEM_BYTEEN    = be_q;
   assign DMEM_WRITEDATA = wd_q;
   assign LOAD_DATA      = ld_q;
   assign BUS_ERROR      = berr_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access controller, directly downstream of the EX/MEM pipeline register.
- Consumes the registered ALU result (address), OUT2 (store data) and the 3-bit MEM_READ/MEM_WRITE codes.
- Runs a request/acknowledge transaction with the data memory and formats load data.
- Drives BUSY_WAIT back to all pipeline registers, freezing the pipeline until the access completes.

Parameters:
- ADDR_W, 32, address width.
- TIMEOUT, 16, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- CLK  input  1  clock.
- reset  input  1  synchronous, active-high.
- MEM_READ  input  3  load op: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 11x reserved (treated as none).
- MEM_WRITE  input  3  store op: 000 none, 001 SB, 010 SH, 011 SW, 1xx reserved (treated as none).
- ADDRESS  input  32  byte address from ALU_RESULT_OUT.
- WRITE_DATA  input  32  store data from OUT2_OUT.
- DMEM_READDATA  input  32  memory read word.
- DMEM_ACK  input  1  memory completion strobe.
- DMEM_READ  output  1  read request.
- DMEM_WRITE  output  1  write request.
- DMEM_ADDR  output  32  word-aligned address ({ADDRESS[31:2],2'b00}).
- DMEM_BYTEEN  output  4  byte lane enables.
- DMEM_WRITEDATA  output  32  lane-replicated store data.
- LOAD_DATA  output  32  extended load result, registered.
- BUSY_WAIT  output  1  pipeline stall.
- MISALIGNED  output  1  misaligned-access flag.
- BUS_ERROR  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset (sync, active-high): state IDLE. Next edge: DMEM_READ=DMEM_WRITE=0, DMEM_ADDR=0, DMEM_BYTEEN=0, DMEM_WRITEDATA=0, LOAD_DATA=0, BUS_ERROR=0, timeout counter=0. BUSY_WAIT=0 and MISALIGNED=0 while in reset. Reset mid-ACCESS aborts the transaction with no ACK wait.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, valid op (legal nonzero code):
  - If aligned: BUSY_WAIT=1 combinationally in the same cycle, so pipeline registers hold. Latch op, ADDRESS[1:0], lanes and data. Next state ACCESS; DMEM_READ or DMEM_WRITE registered high from the first ACCESS cycle.
  - Misaligned (halfword with ADDRESS[0]=1; word with ADDRESS[1:0]!=0): no access, BUSY_WAIT=0, MISALIGNED=1 combinationally while the op is present. Stay IDLE.
  - MEM_READ and MEM_WRITE both nonzero: the read is performed, the write is dropped.
- ACCESS:
  - BUSY_WAIT=1; requests held stable until ACK.
  - On DMEM_ACK: drop request next edge. For loads, register the formatted DMEM_READDATA into LOAD_DATA. Go DONE.
  - Counter increments each ACCESS cycle. If it reaches TIMEOUT (TIMEOUT>0) without ACK: drop request, LOAD_DATA=0, BUS_ERROR=1 for one cycle, go DONE.
- DONE: BUSY_WAIT=0 for exactly one cycle so the pipeline advances. Inputs are ignored (the completed op is still presented). Next state IDLE. LOAD_DATA holds until the next load completes.
- DMEM_ACK outside ACCESS is ignored.
- Latency: ACK in the first ACCESS cycle gives 3 cycles op-to-advance (IDLE, ACCESS, DONE); each wait cycle adds 1.
- Store lanes:
  - SB: data={4{WD[7:0]}}, BYTEEN=4'b0001<<A[1:0].
  - SH: data={2{WD[15:0]}}, BYTEEN=A[1]?1100:0011.
  - SW: data=WD, BYTEEN=1111.
  - Reads drive BYTEEN=1111.
- Load format: select the byte/half lane by latched A[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.

Decomposition:
- Package mem_pkg:
  - load/store op localparams (LB..LHU, SB..SW, NONE).
  - FSM state encoding.
  - lane-select functions.
- Sub-module: load_store_align, purely combinational.
  - Inputs: op, A[1:0], WD, read word.
  - Outputs: BYTEEN, replicated store data, extended load data, misaligned.
  - Instantiated once inside mem_access_unit.

Test Plan:
- LW, ADDRESS=0x100, ACK in the first ACCESS cycle, READDATA=0xDEADBEEF -> BUSY_WAIT high 2 cycles then low 1; DMEM_ADDR=0x100; LOAD_DATA=0xDEADBEEF.
- LB, ADDRESS=0x103, READDATA=0x80FF0000 -> LOAD_DATA=0xFFFFFF80. LBU at the same address -> LOAD_DATA=0x00000080.
- SH, ADDRESS=0x202, WRITE_DATA=0x1234ABCD, ACK after 3 wait cycles -> DMEM_WRITEDATA=0xABCDABCD, BYTEEN=1100, DMEM_WRITE held 4 cycles, BUSY_WAIT high 5 cycles.
- LW, ADDRESS=0x101 -> MISALIGNED=1, BUSY_WAIT=0, DMEM_READ never asserted.
- TIMEOUT=4, no ACK -> request drops after 4 ACCESS cycles, BUS_ERROR one-cycle pulse, LOAD_DATA=0, DONE then IDLE.
- reset asserted in the 2nd ACCESS cycle -> next edge DMEM_READ=0, state IDLE, BUSY_WAIT=0; a late ACK is ignored.
